pdm_audio_out: RTL

//  Output stage downstream of song_player. Consumes its 12-bit mixed audio_out.

---
 rtl/pdm_audio_out.sv | 118 +++++++++++
 1 files changed

// File: rtl/pdm_audio_out.sv
// pdm_audio_out: resample audio, apply volume and mute ramp, drive a first-order sigma-delta pin
`timescale 1ns/1ps
module pdm_audio_out #(
    parameter int SAMPLE_DIV = 256,
    parameter int RAMP_STEPS = 16
) (
    input  logic        main_clk,
    input  logic        rst_n,
    input  logic [11:0] audio_in,
    input  logic [3:0]  volume,
    input  logic        mute,
    output logic        sample_tick,
    output logic        muted,
    output logic [11:0] level,
    output logic        pdm_out
);
    localparam int DW = $clog2(SAMPLE_DIV);
    localparam int RS = $clog2(RAMP_STEPS);
    localparam int RW = RS + 1;
    localparam int PW = 20 + RS;
    localparam logic [RW-1:0] RMAX = RW'(RAMP_STEPS);

    typedef enum logic [1:0] {MUTED, RAMP_UP, PLAY, RAMP_DOWN} state_t;

    state_t state, state_nx;
    logic [DW-1:0] div_cnt;
    logic [11:0] sample_reg;
    logic [RW-1:0] ramp, ramp_nx;
    logic upd;
    logic [4:0] vgain;
    logic signed [PW-1:0] s_x, g_x, r_x, prod;
    logic [11:0] scaled;
    logic [11:0] acc;
    logic [12:0] acc13;
    logic unused_bits;

    assign sample_tick = div_cnt == DW'(SAMPLE_DIV - 1);
    assign muted = state == MUTED;

    // free-running sample divider, wraps after SAMPLE_DIV cycles
    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) div_cnt <= '0;
        else div_cnt <= sample_tick ? '0 : div_cnt + 1'b1;
    end

    // mute/unmute ramp controller; a direction change holds the ramp for one tick
    always_comb begin
        state_nx = state;
        ramp_nx = ramp;
        case (state)
            MUTED: state_nx = mute ? MUTED : RAMP_UP;
            RAMP_UP: begin
                if (mute) state_nx = RAMP_DOWN;
                else begin
                    ramp_nx = (ramp == RMAX) ? ramp : ramp + 1'b1;
                    state_nx = (ramp_nx == RMAX) ? PLAY : RAMP_UP;
                end
            end
            PLAY: state_nx = mute ? RAMP_DOWN : PLAY;
            RAMP_DOWN: begin
                if (!mute) state_nx = RAMP_UP;
                else begin
                    ramp_nx = (ramp == '0) ? ramp : ramp - 1'b1;
                    state_nx = (ramp_nx == '0) ? MUTED : RAMP_DOWN;
                end
            end
            default: state_nx = MUTED;
        endcase
    end

    // capture the sample and advance the ramp only on sample ticks
    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MUTED;
            ramp <= '0;
            sample_reg <= '0;
        end else if (sample_tick) begin
            state <= state_nx;
            ramp <= ramp_nx;
            sample_reg <= audio_in;
        end
    end

    // signed gain product, wide enough that it can never overflow
    always_comb begin
        vgain = {1'b0, volume} + 5'd1;
        s_x = PW'($signed(sample_reg));
        g_x = PW'($signed({1'b0, vgain}));
        r_x = PW'($signed({1'b0, ramp}));
        prod = s_x * g_x * r_x;
        scaled = prod[RS+15:RS+4];
        unused_bits = ^{prod[PW-1:RS+16], prod[RS+3:0]};
    end

    // level is refreshed one cycle after each tick, converted to offset binary
    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            upd <= 1'b0;
            level <= 12'h800;
        end else begin
            upd <= sample_tick;
            if (upd) level <= {~scaled[11], scaled[10:0]};
        end
    end

    assign acc13 = {1'b0, acc} + {1'b0, level};

    // first-order sigma-delta: the accumulator carry is the output bit
    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            pdm_out <= 1'b0;
        end else begin
            acc <= acc13[11:0];
            pdm_out <= acc13[12];
        end
    end
endmodule
